// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment scanner.
// Contents: SEG_BLANK, active-low hex glyph table (seg[0]=a .. seg[6]=g),
// index-width helper, load-handshake state type.
package seg_pkg;

  // All segments off (active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs for 0-F, bit 0 = segment a, bit 6 = segment g.
  localparam logic [6:0] SEG_HEX [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Width of a digit index for n digits (at least 1 bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Load handshake: idle, or new data waiting for the frame boundary.
  typedef enum logic {
    LD_IDLE = 1'b0,
    LD_PEND = 1'b1
  } ld_state_e;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex-to-seven-segment decoder.
// Ports: nibble (in, 4) hex value; seg_c (out, 7) active-low segments a..g.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  assign seg_c = SEG_HEX[nibble];

endmodule

// File: rtl/seg_mux_scanner.sv
// Time-multiplexed seven-segment display scanner with PWM brightness,
// anti-ghosting blank per slot and frame-synchronous double-buffered loads.
// Optional build macro SEG_LZS_EN enables leading-zero suppression.
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   digits          4*NUM_DIGITS hex nibbles, digit i at [4i+3:4i]
//   dp_in           per-digit decimal point, 1 = lit
//   en_mask         per-digit enable, 0 = dark
//   load            one-cycle strobe capturing digits/dp_in
//   brightness      PWM duty code, 0 = dark
//   load_ack        pulse when captured data becomes displayed
//   seg, dp, an     active-low segments, decimal point, anodes (registered)
//   frame_tick      pulse during the last cycle of each frame
module seg_mux_scanner
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned SCAN_DIV     = 65536,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter int unsigned BRIGHT_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   en_mask,
  input  logic                    load,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic                    load_ack,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int unsigned IW = idx_width(NUM_DIGITS);
  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam int unsigned DW = 4 * NUM_DIGITS;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SLOT_BLANK = SW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [SW-1:0]         slot_cnt, slot_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic [DW-1:0]         act_dig, pend_dig;
  logic [NUM_DIGITS-1:0] act_dp, pend_dp;
  ld_state_e             ld_state, ld_nxt;
  logic                  at_boundary, frame_nxt;
  logic                  take_load, take_pend, capture;
  logic [3:0]            cur_nib;
  logic                  cur_dp, lit;
  logic [6:0]            hex_seg_c;
  logic [NUM_DIGITS-1:0] an_nxt;

  // Slot counter and digit index successors.
  always_comb begin
    slot_nxt = slot_cnt + SW'(1);
    idx_nxt  = idx;
    if (slot_cnt == SLOT_LAST) begin
      slot_nxt = '0;
      idx_nxt  = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end
  end

  assign at_boundary = (slot_cnt == SLOT_LAST) && (idx == IDX_LAST);
  // frame_tick is registered from the successor state so it lines up with at_boundary.
  assign frame_nxt   = (slot_nxt == SLOT_LAST) && (idx_nxt == IDX_LAST);

  // Scan counters and frame tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt   <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      slot_cnt   <= slot_nxt;
      idx        <= idx_nxt;
      frame_tick <= frame_nxt;
    end
  end

  // Load handshake state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ld_state <= LD_IDLE;
    else      ld_state <= ld_nxt;
  end

  // Load handshake next state: a load on the boundary bypasses the pending buffer.
  always_comb begin
    ld_nxt    = ld_state;
    take_load = 1'b0;
    take_pend = 1'b0;
    capture   = 1'b0;
    if (at_boundary) begin
      ld_nxt = LD_IDLE;
      if (load)                       take_load = 1'b1;
      else if (ld_state == LD_PEND)   take_pend = 1'b1;
    end else if (load) begin
      capture = 1'b1;
      ld_nxt  = LD_PEND;
    end
  end

  // Ack must cover the bypass case, so it follows load in the boundary cycle.
  assign load_ack = frame_tick & (load | (ld_state == LD_PEND));

  // Pending and active display buffers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_dig <= '0;
      pend_dp  <= '0;
      act_dig  <= '0;
      act_dp   <= '0;
    end else begin
      if (capture) begin
        pend_dig <= digits;
        pend_dp  <= dp_in;
      end
      if (take_load) begin
        act_dig <= digits;
        act_dp  <= dp_in;
      end else if (take_pend) begin
        act_dig <= pend_dig;
        act_dp  <= pend_dp;
      end
    end
  end

  assign cur_nib = act_dig[{idx, 2'b00} +: 4];
  assign cur_dp  = act_dp[idx];

  seg_hex_decode u_dec (
    .nibble (cur_nib),
    .seg_c  (hex_seg_c)
  );

`ifdef SEG_LZS_EN
  logic [NUM_DIGITS-1:0] suppress;
  logic [NUM_DIGITS-1:1] clear_above;

  // Digit i is blank when it and every enabled digit above it are zero.
  always_comb begin
    suppress    = '0;
    clear_above = '1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      suppress[i] = clear_above[i] && (act_dig[4*i +: 4] == 4'h0);
      if (i > 1)
        clear_above[i-1] = clear_above[i] && (!en_mask[i] || (act_dig[4*i +: 4] == 4'h0));
    end
  end

  assign lit = en_mask[idx] && (slot_cnt >= SLOT_BLANK) &&
               (slot_cnt[BRIGHT_W-1:0] < brightness) && !suppress[idx];
`else
  assign lit = en_mask[idx] && (slot_cnt >= SLOT_BLANK) &&
               (slot_cnt[BRIGHT_W-1:0] < brightness);
`endif

  // One-hot active-low anode for the current slot.
  always_comb begin
    an_nxt = '1;
    if (lit) an_nxt[idx] = 1'b0;
  end

  // Registered display outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= hex_seg_c;
      dp  <= ~(cur_dp & lit);
    end
  end

endmodule

// File: tb/tb_seg_mux_scanner.sv
// Directed bench for seg_mux_scanner with 4 digits, 16-cycle slots,
// 2-cycle blank, 2-bit brightness (64-cycle frame).
module tb_seg_mux_scanner;

  localparam int unsigned ND    = 4;
  localparam int unsigned FRAME = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   digits;
  logic [3:0]    dp_in;
  logic [3:0]    en_mask;
  logic          load;
  logic [1:0]    brightness;
  logic          load_ack;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          frame_tick;

  int total = 0;
  int bad   = 0;
  int cyc;

  seg_mux_scanner #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (16),
    .BLANK_CYCLES (2),
    .BRIGHT_W     (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .dp_in      (dp_in),
    .en_mask    (en_mask),
    .load       (load),
    .brightness (brightness),
    .load_ack   (load_ack),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; equals the frame position of the DUT state.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  typedef struct {
    logic [1:0] bright;
    logic [3:0] en;
    int         pos;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to the negedge where cyc mod FRAME equals p (at least one cycle).
  task automatic goto(input int p);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 2 * FRAME + 2 && !hit; i++) begin
      @(negedge clk);
      if (cyc % FRAME == p) hit = 1'b1;
    end
    if (!hit) chk("goto_timeout", 32'd0, 32'd1);
  endtask

  int acks, ack_pos, ft_pos, seen_a;

  initial begin
    // pos = frame position of the state whose registered outputs are checked.
    vecs[0]  = '{2'd3, 4'hF,  0, 4'hF, 7'h19, 1'b1};
    vecs[1]  = '{2'd3, 4'hF,  2, 4'hE, 7'h19, 1'b1};
    vecs[2]  = '{2'd3, 4'hF,  3, 4'hF, 7'h19, 1'b1};
    vecs[3]  = '{2'd3, 4'hF,  4, 4'hE, 7'h19, 1'b1};
    vecs[4]  = '{2'd3, 4'hF, 18, 4'hD, 7'h30, 1'b0};
    vecs[5]  = '{2'd3, 4'hF, 19, 4'hF, 7'h30, 1'b1};
    vecs[6]  = '{2'd1, 4'hF, 20, 4'hD, 7'h30, 1'b0};
    vecs[7]  = '{2'd1, 4'hF, 21, 4'hF, 7'h30, 1'b1};
    vecs[8]  = '{2'd1, 4'hF, 16, 4'hF, 7'h30, 1'b1};
    vecs[9]  = '{2'd0, 4'hF, 36, 4'hF, 7'h24, 1'b1};
    vecs[10] = '{2'd2, 4'hB, 37, 4'hF, 7'h24, 1'b1};
    vecs[11] = '{2'd2, 4'hB, 53, 4'h7, 7'h79, 1'b1};
    vecs[12] = '{2'd3, 4'h1,  8, 4'hE, 7'h19, 1'b1};

    rst = 1'b0; load = 1'b0; digits = 16'h0; dp_in = 4'h0;
    en_mask = 4'hF; brightness = 2'd3;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_ft", 32'(frame_tick), 32'h0);
    chk("rst_ack", 32'(load_ack), 32'h0);

    // Release with a load in cycle 0; ack only at the first boundary.
    rst = 1'b1; load = 1'b1; digits = 16'h1234; dp_in = 4'b0010;
    acks = 0; ack_pos = -1; ft_pos = -1;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      load = 1'b0;
      if (load_ack) begin acks++; ack_pos = cyc; end
      if (frame_tick) ft_pos = cyc;
      if (cyc == 5) begin
        chk("f0_seg_old", 32'(seg), 32'h40);
        chk("f0_an", 32'(an), 32'hE);
      end
    end
    chk("first_ack_cnt", 32'(acks), 32'd1);
    chk("first_ack_pos", 32'(ack_pos), 32'd63);
    chk("first_ft_pos", 32'(ft_pos), 32'd63);

    // Table: anode/segment/dp per slot position, brightness and mask.
    for (int v = 0; v < 13; v++) begin
      brightness = vecs[v].bright;
      en_mask    = vecs[v].en;
      goto((vecs[v].pos + 1) % FRAME);
      chk($sformatf("v%0d_an", v), 32'(an), 32'(vecs[v].an));
      chk($sformatf("v%0d_seg", v), 32'(seg), 32'(vecs[v].seg));
      chk($sformatf("v%0d_dp", v), 32'(dp), 32'(vecs[v].dp));
    end
    brightness = 2'd3; en_mask = 4'hF;

    // Two loads before a boundary: latest wins, single ack.
    goto(10);
    load = 1'b1; digits = 16'hAAAA; dp_in = 4'h0;
    acks = 0; seen_a = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      load = (i == 20);
      if (i == 20) digits = 16'hBBBB;
      if (load_ack) acks++;
      if (seg == 7'h08) seen_a++;
      if (i >= 52 && cyc % FRAME == 3) chk("ll_seg_b", 32'(seg), 32'h03);
    end
    load = 1'b0;
    chk("ll_ack_cnt", 32'(acks), 32'd1);
    chk("ll_never_a", 32'(seen_a), 32'd0);

    // Load exactly on the boundary cycle: bypass with same-cycle ack.
    goto(63);
    chk("byp_ft", 32'(frame_tick), 32'h1);
    load = 1'b1; digits = 16'h5678;
    #1;
    chk("byp_ack", 32'(load_ack), 32'h1);
    @(negedge clk);
    load = 1'b0;
    chk("byp_old_last", 32'(seg), 32'h03);
    @(negedge clk);
    chk("byp_new_slot0", 32'(seg), 32'h00);
    goto(63);
    chk("byp_ft2", 32'(frame_tick), 32'h1);
    chk("byp_no_ack2", 32'(load_ack), 32'h0);

    // Leading zeros: 0050.
    goto(20);
    load = 1'b1; digits = 16'h0050;
    @(negedge clk);
    load = 1'b0;
    goto(63);
    goto(3);
    chk("lz_d0_an", 32'(an), 32'hE);
    chk("lz_d0_seg", 32'(seg), 32'h40);
    goto(19);
    chk("lz_d1_an", 32'(an), 32'hD);
    chk("lz_d1_seg", 32'(seg), 32'h12);
    goto(35);
`ifdef SEG_LZS_EN
    chk("lz_d2_an", 32'(an), 32'hF);
`else
    chk("lz_d2_an", 32'(an), 32'hB);
`endif
    goto(51);
`ifdef SEG_LZS_EN
    chk("lz_d3_an", 32'(an), 32'hF);
`else
    chk("lz_d3_an", 32'(an), 32'h7);
`endif
    chk("lz_d3_seg", 32'(seg), 32'h40);

    // Async reset mid-slot with a pending load.
    goto(35);
    load = 1'b1; digits = 16'h9999;
    @(posedge clk);
    #2;
    load = 1'b0;
    rst = 1'b0;
    #1;
    chk("arst_an", 32'(an), 32'hF);
    chk("arst_seg", 32'(seg), 32'h7F);
    chk("arst_dp", 32'(dp), 32'h1);
    chk("arst_ft", 32'(frame_tick), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    acks = 0; ft_pos = -1;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (load_ack) acks++;
      if (frame_tick) ft_pos = cyc;
      if (cyc == 3) begin
        chk("arst_idx0_an", 32'(an), 32'hE);
        chk("arst_idx0_seg", 32'(seg), 32'h40);
      end
    end
    chk("arst_no_ack", 32'(acks), 32'd0);
    chk("arst_ft_pos", 32'(ft_pos), 32'd63);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
